zluudg_crc16ccitt_check: RTL and testbench

Receive-side counterpart of the CRC16-CCITT FCS appender in the zluudgbee RFNoC chain. It takes 802.15.4 PPDU payload frames with the 2-octet FCS at the end and computes CRC-16/KERMIT over every octet. It strips the FCS, forwards the payload with tlast on the last payload octet, and reports a per-frame ok/error status. It sits between axi_wrapper m_axis_data and s_axis_data in the CRC-check noc_block.

---
 rtl/zluudg_crc_pkg.sv | 23 ++
 rtl/zluudg_crc16_byte.sv | 27 ++
 rtl/zluudg_crc16ccitt_check.sv | 177 +++++++++++++++++
 tb/tb_zluudg_crc16ccitt_check.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zluudg_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zluudg_crc_pkg
// Purpose  : Shared CRC-16/KERMIT constants, mode bits and checker state type.
// Revision : 1.0 - initial release
// ============================================================================
package zluudg_crc_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC16_INIT      = 16'h0000;
    localparam logic [15:0] CRC16_RESIDUE   = 16'h0000;

    localparam int MODE_BYPASS_BIT = 0;
    localparam int MODE_STAMP_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } crc_state_t;

endpackage : zluudg_crc_pkg
`default_nettype wire

// File: rtl/zluudg_crc16_byte.sv
`default_nettype none
// ============================================================================
// Module   : zluudg_crc16_byte
// Purpose  : Combinational one-octet reflected CRC-16 update, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module zluudg_crc16_byte
    import zluudg_crc_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {8'h00, i_byte};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC16_POLY_REFL) : (w_crc >> 1);
        end
    end

    assign o_crc = w_crc;

endmodule : zluudg_crc16_byte
`default_nettype wire

// File: rtl/zluudg_crc16ccitt_check.sv
`default_nettype none
// ============================================================================
// Module   : zluudg_crc16ccitt_check
// Purpose  : Checks and strips the 2-octet FCS of 802.15.4 frames, reporting
//            per-frame status. Optional counters: ZLUUDG_CRC_CHECK_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module zluudg_crc16ccitt_check
    import zluudg_crc_pkg::*;
#(
    parameter int MIN_PAYLOAD = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] sr_crc_mode,
    input  logic [31:0] s_in_tdata,
    input  logic        s_in_tvalid,
    input  logic        s_in_tlast,
    output logic        s_in_tready,
    output logic [31:0] m_out_tdata,
    output logic        m_out_tvalid,
    output logic        m_out_tlast,
    input  logic        m_out_tready,
    output logic        frame_ok_stb,
    output logic        frame_err_stb,
    output logic [31:0] ok_count,
    output logic [31:0] err_count
);

    localparam logic [31:0] c_min_payload = MIN_PAYLOAD;

    logic        r_rst_meta, r_rst_sync;
    crc_state_t  r_state, w_state_nxt;
    logic [1:0]  r_cnt;
    logic [7:0]  r_hold0, r_hold1;
    logic [15:0] r_crc, w_crc_nxt;
    logic [15:0] r_pay;
    logic        r_bypass, r_stamp;
    logic [8:0]  r_out_data;
    logic        r_out_valid, r_out_last;
    logic        r_ok_stb, r_err_stb;

    logic        w_bypass, w_out_free, w_in_ready, w_acc, w_last, w_good;
    logic [7:0]  w_byte;
    logic        w_unused_bits;

    // Reset asserts immediately, releases two edges later in the aclk domain
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_byte     = s_in_tdata[7:0];
    assign w_last     = s_in_tlast;
    assign w_bypass   = (r_state == IDLE) ? sr_crc_mode[MODE_BYPASS_BIT] : r_bypass;
    assign w_out_free = !r_out_valid || m_out_tready;
    assign w_in_ready = !r_rst_sync && ((w_bypass || r_cnt == 2'd2) ? w_out_free : 1'b1);
    assign w_acc      = s_in_tvalid && w_in_ready;
    assign w_good     = (r_cnt == 2'd2) && (w_crc_nxt == CRC16_RESIDUE) &&
                        (({16'd0, r_pay} + 32'd1) >= c_min_payload);
    assign w_unused_bits = ^{s_in_tdata[31:8], sr_crc_mode[31:2]};

    zluudg_crc16_byte u_crc_byte (
        .i_crc  (r_crc),
        .i_byte (w_byte),
        .o_crc  (w_crc_nxt)
    );

    always_ff @(posedge aclk or posedge r_rst_sync) begin
        if (r_rst_sync) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                IDLE:    if (!w_last) w_state_nxt = w_bypass ? RUN : FILL;
                FILL:    if (w_last) w_state_nxt = IDLE;
                         else if (r_cnt == 2'd2) w_state_nxt = RUN;
                RUN:     if (w_last) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_cnt       <= 2'd0;
            r_hold0     <= 8'h00;
            r_hold1     <= 8'h00;
            r_crc       <= CRC16_INIT;
            r_pay       <= 16'd0;
            r_bypass    <= 1'b0;
            r_stamp     <= 1'b0;
            r_out_data  <= 9'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_ok_stb    <= 1'b0;
            r_err_stb   <= 1'b0;
        end else begin
            r_ok_stb  <= 1'b0;
            r_err_stb <= 1'b0;
            if (r_out_valid && m_out_tready) r_out_valid <= 1'b0;
            if (w_acc) begin
                if (r_state == IDLE) begin
                    r_bypass <= sr_crc_mode[MODE_BYPASS_BIT];
                    r_stamp  <= sr_crc_mode[MODE_STAMP_BIT];
                end
                if (w_bypass) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= {1'b0, w_byte};
                    r_out_last  <= w_last;
                end else begin
                    // Hold full: the oldest octet is now known to be payload
                    if (r_cnt == 2'd2) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {w_last && r_stamp && w_good, r_hold0};
                        r_out_last  <= w_last;
                        r_hold0     <= r_hold1;
                        r_hold1     <= w_byte;
                        if (r_pay != 16'hFFFF) r_pay <= r_pay + 16'd1;
                    end else if (r_cnt == 2'd1) begin
                        r_hold1 <= w_byte;
                        r_cnt   <= 2'd2;
                    end else begin
                        r_hold0 <= w_byte;
                        r_cnt   <= 2'd1;
                    end
                    if (w_last) begin
                        r_crc     <= CRC16_INIT;
                        r_cnt     <= 2'd0;
                        r_pay     <= 16'd0;
                        r_ok_stb  <= w_good;
                        r_err_stb <= !w_good;
                    end else begin
                        r_crc <= w_crc_nxt;
                    end
                end
            end
        end
    end

    assign s_in_tready   = w_in_ready;
    assign m_out_tdata   = {23'd0, r_out_data};
    assign m_out_tvalid  = r_out_valid;
    assign m_out_tlast   = r_out_last;
    assign frame_ok_stb  = r_ok_stb;
    assign frame_err_stb = r_err_stb;

`ifdef ZLUUDG_CRC_CHECK_STATS_EN
    logic [31:0] r_ok_count, r_err_count;

    always_ff @(posedge aclk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_ok_count  <= 32'd0;
            r_err_count <= 32'd0;
        end else begin
            if (r_ok_stb)  r_ok_count  <= r_ok_count + 32'd1;
            if (r_err_stb) r_err_count <= r_err_count + 32'd1;
        end
    end

    assign ok_count  = r_ok_count;
    assign err_count = r_err_count;
`else
    assign ok_count  = 32'd0;
    assign err_count = 32'd0;
`endif

endmodule : zluudg_crc16ccitt_check
`default_nettype wire

// File: tb/tb_zluudg_crc16ccitt_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_zluudg_crc16ccitt_check
// Purpose  : Randomised self-checking bench for the CRC16 FCS checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zluudg_crc16ccitt_check;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] sr_crc_mode = 32'd0;
    logic [31:0] s_in_tdata = 32'd0;
    logic        s_in_tvalid = 1'b0;
    logic        s_in_tlast = 1'b0;
    logic        s_in_tready;
    logic [31:0] m_out_tdata;
    logic        m_out_tvalid;
    logic        m_out_tlast;
    logic        m_out_tready = 1'b1;
    logic        frame_ok_stb, frame_err_stb;
    logic [31:0] ok_count, err_count;

    zluudg_crc16ccitt_check dut (
        .aclk          (aclk),
        .areset        (areset),
        .sr_crc_mode   (sr_crc_mode),
        .s_in_tdata    (s_in_tdata),
        .s_in_tvalid   (s_in_tvalid),
        .s_in_tlast    (s_in_tlast),
        .s_in_tready   (s_in_tready),
        .m_out_tdata   (m_out_tdata),
        .m_out_tvalid  (m_out_tvalid),
        .m_out_tlast   (m_out_tlast),
        .m_out_tready  (m_out_tready),
        .frame_ok_stb  (frame_ok_stb),
        .frame_err_stb (frame_err_stb),
        .ok_count      (ok_count),
        .err_count     (err_count)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Entries: {mode[1:0], first, last, data[7:0]}
    logic [11:0] frame_q[$];
    logic [7:0]  cur_f[$];
    logic [9:0]  exp_q[$];   // {stamp, data, last}
    logic [9:0]  obs_q[$];
    int n_ok = 0, n_err = 0, n_both = 0;
    int exp_ok = 0, exp_err = 0, tot_ok = 0, tot_err = 0;
    int hold_viol = 0, hi_viol = 0;
    int rdy_pct = 100, gap_pct = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = 10'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Textbook bitwise CRC-16/KERMIT over the bytes in cur_f
    function automatic logic [15:0] kermit_of_cur();
        logic [15:0] c = 16'h0000;
        logic        fb;
        foreach (cur_f[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ cur_f[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic model_frame(input logic [1:0] mode);
        int          n;
        logic        pass;
        n    = cur_f.size();
        pass = (kermit_of_cur() == 16'h0000);
        for (int i = 0; i < n; i++)
            frame_q.push_back({mode, i == 0, i == n - 1, cur_f[i]});
        if (mode[0]) begin
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, cur_f[i], i == n - 1});
        end else if (n < 3) begin
            exp_err++; tot_err++;
        end else begin
            for (int i = 0; i < n - 2; i++)
                exp_q.push_back({(i == n - 3) && mode[1] && pass, cur_f[i], i == n - 3});
            if (pass) begin exp_ok++; tot_ok++; end
            else begin exp_err++; tot_err++; end
        end
    endtask

    task automatic make_good(input int npay);
        logic [15:0] c;
        cur_f.delete();
        for (int i = 0; i < npay; i++) cur_f.push_back(8'($urandom));
        c = kermit_of_cur();
        cur_f.push_back(c[7:0]);
        cur_f.push_back(c[15:8]);
    endtask

    task automatic load_test1(input logic [7:0] last_fcs);
        cur_f.delete();
        for (int i = 0; i < 9; i++) cur_f.push_back(8'h31 + 8'(i));
        cur_f.push_back(8'h89);
        cur_f.push_back(last_fcs);
    endtask

    task automatic send_q();
        int          guard;
        logic [31:0] rnd;
        while (frame_q.size() > 0) begin
            @(negedge aclk);
            if ($urandom_range(99) < gap_pct) begin
                s_in_tvalid = 1'b0;
                continue;
            end
            rnd = $urandom;
            if (frame_q[0][9]) sr_crc_mode = {30'd0, frame_q[0][11:10]};
            else               sr_crc_mode = $urandom;
            s_in_tdata  = {rnd[31:8], frame_q[0][7:0]};
            s_in_tlast  = frame_q[0][8];
            s_in_tvalid = 1'b1;
            guard = 0;
            #4;
            while (!s_in_tready && guard < 1000) begin
                @(negedge aclk); #4; guard++;
            end
            if (guard >= 1000) begin
                check("in_ready_timeout", 1, 0);
                frame_q.delete();
            end else begin
                @(posedge aclk);
                void'(frame_q.pop_front());
            end
        end
        @(negedge aclk);
        s_in_tvalid = 1'b0;
        s_in_tlast  = 1'b0;
        sr_crc_mode = 32'd0;
    endtask

    task automatic drain();
        int g = 0;
        while (obs_q.size() < exp_q.size() && g < 3000) begin
            @(negedge aclk); g++;
        end
        repeat (6) @(negedge aclk);
    endtask

    task automatic verify(input string tag);
        int nbad = 0;
        int m;
        check({tag, " beats"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) nbad++;
        check({tag, " beat_mismatches"}, nbad, 0);
        check({tag, " ok_stb"}, n_ok, exp_ok);
        check({tag, " err_stb"}, n_err, exp_err);
`ifdef ZLUUDG_CRC_CHECK_STATS_EN
        check({tag, " ok_count"}, ok_count, tot_ok);
        check({tag, " err_count"}, err_count, tot_err);
`else
        check({tag, " counters"}, {ok_count, err_count}, 0);
`endif
        obs_q.delete(); exp_q.delete();
        n_ok = 0; n_err = 0; exp_ok = 0; exp_err = 0;
    endtask

    initial forever begin
        @(negedge aclk);
        m_out_tready = ($urandom_range(99) < rdy_pct);
    end

    initial forever begin
        @(negedge aclk);
        #4;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_out_tvalid && {m_out_tdata[8:0], m_out_tlast} == prev_beat))
                hold_viol++;
            if (m_out_tvalid && m_out_tdata[31:9] != 23'd0) hi_viol++;
            if (m_out_tvalid && m_out_tready) obs_q.push_back({m_out_tdata[8:0], m_out_tlast});
            if (frame_ok_stb)  n_ok++;
            if (frame_err_stb) n_err++;
            if (frame_ok_stb && frame_err_stb) n_both++;
            prev_stall = m_out_tvalid && !m_out_tready;
            prev_beat  = {m_out_tdata[8:0], m_out_tlast};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlast;
        repeat (4) @(negedge aclk);
        #1;
        check("reset ctrl", {s_in_tready, m_out_tvalid, m_out_tlast, frame_ok_stb, frame_err_stb}, 0);
        check("reset tdata", m_out_tdata, 0);
        check("reset counts", {ok_count, err_count}, 0);
        @(negedge aclk);
        areset = 1'b0;
        repeat (5) @(negedge aclk);

        load_test1(8'h21); model_frame(2'd0); send_q(); drain(); verify("t1_good");
        load_test1(8'h20); model_frame(2'd0); send_q(); drain(); verify("t2_bad");
        load_test1(8'h20); model_frame(2'd2); send_q(); drain(); verify("t2_bad_stamp");
        load_test1(8'h21); model_frame(2'd2); send_q(); drain(); verify("t2_good_stamp");

        cur_f.delete(); cur_f.push_back(8'h00); cur_f.push_back(8'h00);
        model_frame(2'd0); send_q(); drain(); verify("t3_runt2");
        cur_f.delete(); cur_f.push_back(8'h00);
        model_frame(2'd0); send_q(); drain(); verify("t3_runt1");

        load_test1(8'h21); model_frame(2'd1); send_q(); drain(); verify("t5_bypass");

        rdy_pct = 30;
        for (int f = 0; f < 100; f++) begin
            make_good($urandom_range(1, 16));
            model_frame(2'd0);
        end
        send_q(); drain(); verify("t4_b2b");

        rdy_pct = 60; gap_pct = 20;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(4) == 0) begin
                cur_f.delete();
                repeat ($urandom_range(1, 2)) cur_f.push_back(8'($urandom));
            end else begin
                make_good($urandom_range(1, 10));
                if ($urandom_range(2) == 0)
                    cur_f[$urandom_range(cur_f.size() - 1)] ^= 8'(1 << $urandom_range(7));
            end
            model_frame(2'($urandom_range(3)));
        end
        send_q(); drain(); verify("mixed");

        rdy_pct = 100; gap_pct = 0;
        load_test1(8'h21);
        for (int i = 0; i < 5; i++) frame_q.push_back({2'd0, i == 0, 1'b0, cur_f[i]});
        send_q();
        areset = 1'b1;
        #1;
        check("t6 reset ctrl", {s_in_tready, m_out_tvalid, m_out_tlast, frame_ok_stb, frame_err_stb}, 0);
        check("t6 reset tdata", m_out_tdata, 0);
        check("t6 reset counts", {ok_count, err_count}, 0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        repeat (5) @(negedge aclk);
        nlast = 0;
        foreach (obs_q[i]) if (obs_q[i][0]) nlast++;
        check("t6 partial tlast", nlast, 0);
        check("t6 partial strobes", n_ok + n_err, 0);
        obs_q.delete(); n_ok = 0; n_err = 0; tot_ok = 0; tot_err = 0;
        load_test1(8'h21); model_frame(2'd0); send_q(); drain(); verify("t6_after_reset");

        check("hold_stable", hold_viol, 0);
        check("tdata_high_zero", hi_viol, 0);
        check("ok_err_exclusive", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_zluudg_crc16ccitt_check
`default_nettype wire
